// File: rtl/ram_arbiter.sv
// Two-port RAM arbiter: CPU (port 0) and host loader (port 1) share one
// synchronous RAM with zero-cycle round-robin arbitration and a port-1 bus lock.
module ram_arbiter #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_req0,
  input  logic              i_req1,
  input  logic              i_we0,
  input  logic              i_we1,
  input  logic [ADDR_W-1:0] i_addr0,
  input  logic [ADDR_W-1:0] i_addr1,
  input  logic [DATA_W-1:0] i_wdata0,
  input  logic [DATA_W-1:0] i_wdata1,
  input  logic              i_lock1,
  output logic              o_gnt0,
  output logic              o_gnt1,
  output logic              o_rvalid0,
  output logic              o_rvalid1,
  output logic [DATA_W-1:0] o_rdata,
  output logic [ADDR_W-1:0] o_ram_addr,
  output logic [DATA_W-1:0] o_ram_data,
  output logic              o_ram_wren,
  input  logic [DATA_W-1:0] i_ram_q,
  output logic [1:0]        o_owner
);

  typedef enum logic {ARB, LOCK1} state_t;

  state_t state, state_next;
  logic   favour1;

  // Grants are combinational so a lone requester is served in the cycle it asks.
  always_comb begin
    o_gnt0     = 1'b0;
    o_gnt1     = 1'b0;
    state_next = state;
    if (!i_reset) begin
      if (state == LOCK1) begin
        o_gnt1 = i_req1;
        if (!i_lock1) state_next = ARB;
      end else begin
        if (i_req0 && i_req1) begin
          o_gnt1 = favour1;
          o_gnt0 = !favour1;
        end else begin
          o_gnt0 = i_req0;
          o_gnt1 = i_req1;
        end
        if (o_gnt1 && i_lock1) state_next = LOCK1;
      end
    end
  end

  assign o_ram_addr = o_gnt1 ? i_addr1 : i_addr0;
  assign o_ram_data = o_gnt1 ? i_wdata1 : i_wdata0;
  assign o_ram_wren = (o_gnt0 & i_we0) | (o_gnt1 & i_we1);
  assign o_rdata    = i_ram_q;

  // The RAM answers one cycle after the grant, so rvalid is the registered read grant.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state     <= ARB;
      favour1   <= 1'b0;
      o_rvalid0 <= 1'b0;
      o_rvalid1 <= 1'b0;
      o_owner   <= 2'b00;
    end else begin
      state     <= state_next;
      if (o_gnt0 || o_gnt1) favour1 <= o_gnt0;
      o_rvalid0 <= o_gnt0 & ~i_we0;
      o_rvalid1 <= o_gnt1 & ~i_we1;
      o_owner   <= {o_gnt1, o_gnt0};
    end
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed self-checking bench for ram_arbiter with a behavioural synchronous RAM.
module tb_ram_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic       req0, req1, we0, we1, lock1;
  logic [7:0] addr0, addr1, wdata0, wdata1;
  logic       gnt0, gnt1, rvalid0, rvalid1, ram_wren;
  logic [7:0] rdata, ram_addr, ram_data, ram_q;
  logic [1:0] owner;
  logic [7:0] mem [256];
  int         checks = 0;
  int         errors = 0;

  ram_arbiter #(.ADDR_W(8), .DATA_W(8)) dut (
    .i_clk(clk), .i_reset(reset),
    .i_req0(req0), .i_req1(req1), .i_we0(we0), .i_we1(we1),
    .i_addr0(addr0), .i_addr1(addr1), .i_wdata0(wdata0), .i_wdata1(wdata1),
    .i_lock1(lock1), .o_gnt0(gnt0), .o_gnt1(gnt1),
    .o_rvalid0(rvalid0), .o_rvalid1(rvalid1), .o_rdata(rdata),
    .o_ram_addr(ram_addr), .o_ram_data(ram_data), .o_ram_wren(ram_wren),
    .i_ram_q(ram_q), .o_owner(owner)
  );

  always #5 clk = ~clk;

  // Read-before-write RAM with one cycle of read latency.
  always @(posedge clk) begin
    if (ram_wren) mem[ram_addr] <= ram_data;
    ram_q <= mem[ram_addr];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic r0, input logic w0, input logic [7:0] a0,
                               input logic [7:0] d0, input logic r1, input logic w1,
                               input logic [7:0] a1, input logic [7:0] d1, input logic l1);
    req0 = r0; we0 = w0; addr0 = a0; wdata0 = d0;
    req1 = r1; we1 = w1; addr1 = a1; wdata1 = d1;
    lock1 = l1;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  initial begin
    // Reset forces grants and write enable low even with a request pending.
    reset = 1'b1;
    applyStimulus(1, 1, 8'h00, 8'hFF, 0, 0, 8'h00, 8'h00, 0);
    checkOutput("rst_gnt0", gnt0, 0);
    checkOutput("rst_wren", ram_wren, 0);
    tick(); tick();
    checkOutput("rst_rvalid0", rvalid0, 0);
    checkOutput("rst_rvalid1", rvalid1, 0);
    checkOutput("rst_owner", owner, 2'b00);

    // Host loader writes 0x5A to 0x10.
    reset = 1'b0;
    applyStimulus(0, 0, 8'h00, 8'h00, 1, 1, 8'h10, 8'h5A, 0);
    checkOutput("load_gnt1", gnt1, 1);
    checkOutput("load_wren", ram_wren, 1);
    checkOutput("load_addr", ram_addr, 8'h10);
    checkOutput("load_data", ram_data, 8'h5A);
    tick();
    checkOutput("load_owner", owner, 2'b10);
    checkOutput("load_rvalid1", rvalid1, 0);

    // Single read by port 0.
    applyStimulus(1, 0, 8'h10, 8'h00, 0, 0, 8'h00, 8'h00, 0);
    checkOutput("rd_gnt0", gnt0, 1);
    checkOutput("rd_gnt1", gnt1, 0);
    checkOutput("rd_addr", ram_addr, 8'h10);
    checkOutput("rd_wren", ram_wren, 0);
    tick();
    checkOutput("rd_rvalid0", rvalid0, 1);
    checkOutput("rd_rdata", rdata, 8'h5A);
    checkOutput("rd_owner", owner, 2'b01);
    applyStimulus(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 0);
    tick();
    checkOutput("rd_rvalid0_end", rvalid0, 0);

    // Contention from reset alternates 0,1,0,1.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    applyStimulus(1, 0, 8'h01, 8'h00, 1, 0, 8'h02, 8'h00, 0);
    for (int i = 0; i < 4; i++) begin
      checkOutput("rr_gnt0", gnt0, (i % 2) == 0);
      checkOutput("rr_gnt1", gnt1, (i % 2) == 1);
      checkOutput("rr_exclusive", gnt0 & gnt1, 0);
      checkOutput("rr_addr", ram_addr, ((i % 2) == 1) ? 8'h02 : 8'h01);
      tick();
      checkOutput("rr_rvalid0", rvalid0, (i % 2) == 0);
      checkOutput("rr_rvalid1", rvalid1, (i % 2) == 1);
    end

    // Port 1 writes 0xC3 to 0x20, then port 0 reads it back.
    applyStimulus(0, 0, 8'h00, 8'h00, 1, 1, 8'h20, 8'hC3, 0);
    checkOutput("wr_gnt1", gnt1, 1);
    checkOutput("wr_wren", ram_wren, 1);
    checkOutput("wr_data", ram_data, 8'hC3);
    tick();
    checkOutput("wr_rvalid1", rvalid1, 0);
    applyStimulus(1, 0, 8'h20, 8'h00, 0, 0, 8'h00, 8'h00, 0);
    checkOutput("wrd_gnt0", gnt0, 1);
    tick();
    checkOutput("wrd_rdata", rdata, 8'hC3);
    checkOutput("wrd_rvalid0", rvalid0, 1);
    checkOutput("wrd_rvalid1", rvalid1, 0);

    // Port 1 locks for 4 cycles; port 0 keeps requesting.
    applyStimulus(1, 0, 8'h10, 8'h00, 1, 0, 8'h30, 8'h00, 1);
    for (int i = 0; i < 4; i++) begin
      checkOutput("lk_gnt1", gnt1, 1);
      checkOutput("lk_gnt0", gnt0, 0);
      tick();
    end
    applyStimulus(1, 0, 8'h10, 8'h00, 0, 0, 8'h30, 8'h00, 0);
    checkOutput("lk_fall_gnt0", gnt0, 0);
    checkOutput("lk_fall_gnt1", gnt1, 0);
    checkOutput("lk_fall_wren", ram_wren, 0);
    tick();
    checkOutput("lk_idle_owner", owner, 2'b00);
    checkOutput("lk_after_gnt0", gnt0, 1);
    tick();
    checkOutput("lk_after_rvalid0", rvalid0, 1);
    checkOutput("lk_after_rdata", rdata, 8'h5A);

    // Reset lands on the edge ending a granted read; pointer favoured port 1 before.
    applyStimulus(1, 0, 8'h10, 8'h00, 0, 0, 8'h00, 8'h00, 0);
    checkOutput("rm_gnt0", gnt0, 1);
    reset = 1'b1;
    #1;
    checkOutput("rm_gnt0_forced", gnt0, 0);
    tick();
    checkOutput("rm_rvalid0", rvalid0, 0);
    checkOutput("rm_owner", owner, 2'b00);
    reset = 1'b0;
    applyStimulus(1, 0, 8'h01, 8'h00, 1, 0, 8'h02, 8'h00, 0);
    checkOutput("rm_ptr_gnt0", gnt0, 1);
    checkOutput("rm_ptr_gnt1", gnt1, 0);

    // A lock in progress is dropped by reset.
    applyStimulus(0, 0, 8'h01, 8'h00, 1, 0, 8'h02, 8'h00, 1);
    checkOutput("la_gnt1", gnt1, 1);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    applyStimulus(1, 0, 8'h01, 8'h00, 1, 0, 8'h02, 8'h00, 1);
    checkOutput("la_gnt0", gnt0, 1);
    checkOutput("la_gnt1", gnt1, 0);

    // Idle: nothing requested for 8 cycles; RAM address rests on port 0.
    applyStimulus(0, 1, 8'h44, 8'h99, 0, 1, 8'h55, 8'h77, 0);
    for (int i = 0; i < 8; i++) begin
      tick();
      checkOutput("idle_wren", ram_wren, 0);
      checkOutput("idle_rvalid0", rvalid0, 0);
      checkOutput("idle_rvalid1", rvalid1, 0);
      checkOutput("idle_owner", owner, 2'b00);
      checkOutput("idle_addr", ram_addr, 8'h44);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ram_arbiter.md
RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 Parameter: ADDR_W, default 8, RAM address width.
REQ-002 Parameter: DATA_W, default 8, RAM data width.
REQ-003 i_clk  input  1  clock; all state updates on rising edge.
REQ-004 i_reset  input  1  synchronous, active-high reset.
REQ-005 i_req0 / i_req1  input  1  access request, port 0 (CPU) / port 1 (host loader).
REQ-006 i_we0 / i_we1  input  1  1 = write, 0 = read; qualified by the port's request.
REQ-007 i_addr0 / i_addr1  input  ADDR_W  access address.
REQ-008 i_wdata0 / i_wdata1  input  DATA_W  write data.
REQ-009 i_lock1  input  1  host bus lock; keeps port 1 granted across consecutive cycles.
REQ-010 o_gnt0 / o_gnt1  output  1  combinational grant; the access completes at the rising edge that ends the grant cycle.
REQ-011 o_rvalid0 / o_rvalid1  output  1  registered; read data valid for that port this cycle.
REQ-012 o_rdata  output  DATA_W  shared read data, direct pass-through of i_ram_q.
REQ-013 o_ram_addr / o_ram_data  output  ADDR_W / DATA_W  RAM address and write data, muxed from the granted port.
REQ-014 o_ram_wren  output  1  RAM write enable.
REQ-015 i_ram_q  input  DATA_W  RAM output; valid one cycle after its address is sampled.
REQ-016 o_owner  output  2  registered last owner: 00 none, 01 port 0, 10 port 1.

Function
REQ-017 The arbiter SHALL grant at most one port per cycle; o_gnt0 & o_gnt1 SHALL never both be 1.
REQ-018 Two states: ARB and LOCK1.
REQ-019 In ARB, a single requester SHALL be granted in the same cycle it requests (zero-cycle arbitration).
REQ-020 In ARB, with both ports requesting, the grant SHALL go to the port not granted most recently (round-robin pointer); after reset the pointer favours port 0.
REQ-021 The pointer SHALL update only on cycles in which a grant is issued.
REQ-022 ARB->LOCK1 SHALL occur at the edge ending a port-1 grant cycle while i_lock1=1.
REQ-023 In LOCK1, port 1 SHALL have absolute priority and port 0 SHALL not be granted; LOCK1->ARB when i_lock1=0, effective from the next cycle.
REQ-024 In LOCK1, i_req1=0 SHALL produce no grant and leave the RAM idle.
REQ-025 o_ram_addr/o_ram_data SHALL follow the granted port; with no grant they SHALL hold port 0's values and o_ram_wren SHALL be 0.
REQ-026 o_ram_wren SHALL equal the granted port's i_we.
REQ-027 A granted read in cycle N SHALL assert that port's o_rvalid for exactly cycle N+1, with o_rdata = i_ram_q.
REQ-028 Granted writes SHALL never assert o_rvalid.
REQ-029 Back-to-back reads SHALL sustain one read per cycle; rvalid pulses follow grants one-for-one in order.
REQ-030 A port SHALL hold req/we/addr/wdata stable until it sees gnt.
REQ-031 o_owner SHALL register the granted port each edge, or 00 on no-grant cycles.

Reset
REQ-032 While i_reset=1, o_gnt0, o_gnt1 and o_ram_wren SHALL be forced to 0 combinationally.
REQ-033 At a reset edge: state <= ARB, pointer <= favour port 0, o_rvalid0/1 <= 0, o_owner <= 00.
REQ-034 A read granted in the cycle before reset asserts SHALL produce no rvalid.
REQ-035 In-flight LOCK1 SHALL be abandoned on reset.

Verification
REQ-036 Single read: port 0 reads addr 0x10 (RAM holds 0x5A) -> o_gnt0=1 same cycle; next cycle o_rvalid0=1, o_rdata=0x5A.
REQ-037 Contention: both ports request every cycle from reset -> grants alternate 0,1,0,1; never both high.
REQ-038 Write then read: port 1 writes 0xC3 to 0x20, then port 0 reads 0x20 -> o_rdata=0xC3 with o_rvalid0=1 and o_rvalid1=0.
REQ-039 Lock: port 1 granted with i_lock1=1 for 4 cycles while port 0 requests -> port 0 is not granted; o_gnt0=1 in the first cycle after i_lock1 falls.
REQ-040 Reset mid-read: read granted at cycle N, i_reset=1 at the edge ending cycle N -> o_rvalid0=0 at N+1, o_owner=00, pointer favours port 0.
REQ-041 Idle: no requests for 8 cycles -> o_ram_wren=0, o_rvalid0/1=0, o_owner=00 throughout.
